dsp38_mac_sequencer: RTL and testbench
======================================

Name: dsp38_mac_sequencer

Overview:
Controller that sequences a DSP38-class 20x18 multiply-accumulate datapath to compute length-N dot products, z = sum(a[i]*b[i]).
- Accepts a job command (start + length).
- Streams operand pairs in over a valid/ready handshake.
- Clears, accumulates and drains the MAC pipeline, then presents the 38-bit result over a valid/ready handshake.
- Sits between a requester (DMA/FSM) and the MAC primitive; the primitive model is instantiated inside as a sub-module.

Parameters:
- LEN_W, 8, width of job length field; max job length 2^LEN_W-1.
- PIPE, 1, MAC pipeline depth in cycles from operand accept to accumulator update (1..4).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  job request; sampled only in IDLE.
- len  input  LEN_W  number of operand pairs in the job; sampled with start.
- op_valid  input  1  operand pair valid.
- op_ready  output  1  sequencer accepts operand pair.
- op_a  input  20  multiplicand, unsigned.
- op_b  input  18  multiplier, unsigned.
- res_valid  output  1  result valid; held until accepted.
- res_ready  input  1  downstream accepts result.
- res_z  output  38  accumulated result, modulo 2^38.
- res_ovf  output  1  sticky: a carry out of bit 37 occurred during the job.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high. On reset assertion, immediately: state=IDLE, op_ready=0, res_valid=0, res_z=0, res_ovf=0, busy=0, internal counters=0, MAC pipeline and accumulator=0.
- IDLE:
  - start=1 and len!=0: latch len, synchronously clear accumulator and ovf, go to RUN.
  - start=1 and len==0: go to DONE with res_z=0 and res_ovf=0. res_valid rises on the next edge.
- RUN:
  - op_ready=1 while accepted count < len.
  - A transfer occurs on op_valid & op_ready at a rising edge.
  - Each transfer pushes op_a*op_b (38-bit unsigned product, never exceeds 2^38-1) into the MAC. The accumulator updates PIPE cycles later: acc <= acc + product, truncated to 38 bits.
  - ovf is set if the 39th sum bit is 1.
  - The transfer of pair number len moves to DRAIN. op_ready drops in the same cycle the state leaves RUN; it is combinational from state/count.
  - Gaps in op_valid are allowed at any point; the count holds.
- DRAIN: wait PIPE cycles until the last product has been accumulated, then go to DONE.
- DONE:
  - res_valid=1, and res_z/res_ovf are stable.
  - On res_valid & res_ready, go to IDLE. res_valid falls on the next edge; res_z holds its value until the next job clears it.
- Latency: minimum cycles from start to res_valid = 1 + len + PIPE, with no op_valid gaps and operands presented from the first RUN cycle.
- start outside IDLE is ignored (no queuing).
- start and res_ready asserted in the same cycle while in DONE: the result is consumed, and start is ignored that cycle because the state is not yet IDLE.
- op_valid outside RUN: no transfer; the data is ignored.
- Reset mid-job (any state): job abandoned, no res_valid produced, all state returns to reset values; the first start after reset deassertion is honoured.

Decomposition:
- Package dsp38_pkg holds:
  - A_W=20, B_W=18, Z_W=38.
  - State enum seq_state_t {IDLE, RUN, DRAIN, DONE}.
  - Product/accumulator typedefs.
- Sub-module dsp38_mac_core:
  - PIPE-stage registered multiply.
  - Accumulator with synchronous clear and accumulate-enable.
  - Carry-out flag.
  - Shares clk/reset.
- Sequencer holds the FSM, the length counter and the drain counter.

Test Plan:
- Reset: assert reset mid-cycle with random inputs → all outputs 0 immediately; hold 2 cycles; outputs remain 0.
- Single pair: start, len=1, a=20'h7FFFF, b=18'h1FFFF → res_z=38'h0FFFF60001, res_ovf=0, res_valid exactly 2+PIPE cycles after start.
- Stream with gaps: len=4; pairs (1,10),(2,10),(3,10),(4,10); op_valid low 2 cycles between pairs 2 and 3 → res_z=100; op_ready low after the 4th transfer.
- Overflow: len=3; a=20'hFFFFF, b=18'h3FFFF each → res_z=38'h3FFFC40003, res_ovf=1.
- Back-pressure and edge cases:
  - res_ready low for 5 cycles → res_valid/res_z held.
  - start pulsed during DONE → ignored.
  - len=0 → res_valid one cycle after start, res_z=0.
- Reset mid-RUN: after 2 of 5 pairs, pulse reset → no result; next job len=1 (3,5) → res_z=15.
- Random: 600 jobs, random len 1..16 and operands, random valid/ready stalls, compared against a 38-bit modular reference sum and overflow flag.

Source files
------------

// File: rtl/dsp38_pkg.sv
// Shared widths, state encoding and operand/product types for the DSP38 MAC sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package dsp38_pkg;

    localparam int A_W = 20;
    localparam int B_W = 18;
    localparam int Z_W = 38;

    typedef logic [A_W-1:0] opa_t;
    typedef logic [B_W-1:0] opb_t;
    typedef logic [Z_W-1:0] prod_t;
    typedef logic [Z_W-1:0] acc_t;
    typedef logic [Z_W:0]   sum_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;

    // 20x18 unsigned product always fits in 38 bits.
    function automatic prod_t mul(input opa_t a, input opb_t b);
        return prod_t'(a) * prod_t'(b);
    endfunction

endpackage

// File: rtl/dsp38_mac_core.sv
// DSP38 MAC primitive: PIPE-stage registered multiply feeding a 38-bit accumulator with sticky carry-out.
// Latency: accumulator reflects a pushed pair PIPE cycles after the push.
// Backpressure: none; accepts a push every cycle.
module dsp38_mac_core
    import dsp38_pkg::*;
#(
    parameter int PIPE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic push,
    input  opa_t a,
    input  opb_t b,
    output acc_t acc,
    output logic ovf
);

    prod_t            pipe_dat [PIPE];
    logic [PIPE-1:0]  pipe_vld;
    sum_t             sum;

    assign sum = {1'b0, acc} + {1'b0, pipe_dat[PIPE-1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE; i++) begin
                pipe_dat[i] <= '0;
            end
            pipe_vld <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
        end else begin
            if (push) begin
                pipe_dat[0] <= mul(a, b);
            end
            pipe_vld[0] <= push;
            for (int i = 1; i < PIPE; i++) begin
                pipe_dat[i] <= pipe_dat[i-1];
                pipe_vld[i] <= pipe_vld[i-1];
            end
            if (clr) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (pipe_vld[PIPE-1]) begin
                acc <= sum[Z_W-1:0];
                ovf <= ovf | sum[Z_W];
            end
        end
    end

endmodule

// File: rtl/dsp38_mac_sequencer.sv
// Dot-product sequencer: takes a job (start+len), streams len operand pairs into the MAC core, drains, presents the result.
// Latency: start to res_valid = 1 + len + PIPE cycles with no operand gaps; len==0 gives res_valid one cycle after start.
// Backpressure: op_ready only while RUN and pairs remain; res_valid holds in DONE until res_ready.
module dsp38_mac_sequencer
    import dsp38_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int PIPE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [A_W-1:0]   op_a,
    input  logic [B_W-1:0]   op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [Z_W-1:0]   res_z,
    output logic             res_ovf,
    output logic             busy
);

    localparam logic [2:0] DRAIN_LAST = 3'(PIPE - 1);

    seq_state_t       state, state_nxt;
    logic [LEN_W-1:0] len_q, len_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [2:0]       dcnt, dcnt_nxt;
    logic             clr;
    logic             push;

    assign op_ready  = (state == RUN) && (cnt < len_q);
    assign push      = op_valid && op_ready;
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            len_q <= '0;
            cnt   <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nxt;
            len_q <= len_nxt;
            cnt   <= cnt_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len_q;
        cnt_nxt   = cnt;
        dcnt_nxt  = dcnt;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    // Clearing on every accepted job also gives len==0 a zero result.
                    clr       = 1'b1;
                    len_nxt   = len;
                    cnt_nxt   = '0;
                    state_nxt = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (push) begin
                    cnt_nxt = cnt + LEN_W'(1);
                    if (cnt_nxt == len_q) begin
                        dcnt_nxt  = '0;
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                dcnt_nxt = dcnt + 3'd1;
                if (dcnt == DRAIN_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    dsp38_mac_core #(
        .PIPE (PIPE)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (push),
        .a     (op_a),
        .b     (op_b),
        .acc   (res_z),
        .ovf   (res_ovf)
    );

endmodule

// File: tb/tb_dsp38_mac_sequencer.sv
// Scoreboard bench for dsp38_mac_sequencer: stimulus pushes expected results, a monitor pops on each result handshake.
module tb_dsp38_mac_sequencer;
    import dsp38_pkg::*;

    localparam int LEN_W = 8;
    localparam int PIPE  = 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [19:0]      op_a = '0;
    logic [17:0]      op_b = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [37:0]      res_z;
    logic             res_ovf;
    logic             busy;

    typedef struct packed {
        logic [37:0] z;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    int          rdy_mode = 0;
    logic [19:0] ja[16];
    logic [17:0] jb[16];

    dsp38_mac_sequencer #(.LEN_W(LEN_W), .PIPE(PIPE)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_z     (res_z),
        .res_ovf   (res_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_op_ready"},  64'(op_ready),  64'd0);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_res_z"},     64'(res_z),     64'd0);
        chk({tag, "_res_ovf"},   64'(res_ovf),   64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    // Result monitor: every handshake must match the oldest pending expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got z=%h with no result expected", res_z);
                end else begin
                    mon_e = sb.pop_front();
                    chk("res_z", 64'(res_z), 64'(mon_e.z));
                    chk("res_ovf", 64'(res_ovf), 64'(mon_e.ovf));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = ($urandom_range(0, 3) != 0);
                default: res_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input int n);
        exp_t       e;
        logic [38:0] s;
        e = '0;
        for (int i = 0; i < n; i++) begin
            s     = {1'b0, e.z} + (39'(ja[i]) * 39'(jb[i]));
            e.ovf = e.ovf | s[38];
            e.z   = s[37:0];
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input int n);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
    endtask

    // gapmode 0: none, 1: two idle cycles before the third pair, 2: random gaps.
    task automatic feed(input int n, input int gapmode, input bit chk_drop);
        int g;
        bit done;
        for (int i = 0; i < n; i++) begin
            g = 0;
            if (gapmode == 1 && i == 2) g = 2;
            if (gapmode == 2 && $urandom_range(0, 3) == 0) g = $urandom_range(1, 3);
            op_valid = 1'b0;
            repeat (g) tick();
            op_valid = 1'b1;
            op_a     = ja[i];
            op_b     = jb[i];
            done     = 1'b0;
            for (int t = 0; t < 100 && !done; t++) begin
                @(negedge clk);
                if (op_ready) done = 1'b1;
                @(posedge clk);
                #1;
            end
            if (!done) chk("op_ready_timeout", 64'd0, 64'd1);
        end
        op_valid = 1'b0;
        if (chk_drop) begin
            @(negedge clk);
            chk("op_ready_after_last", 64'(op_ready), 64'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 500 && !done; t++) begin
            if (!busy) done = 1'b1;
            else tick();
        end
        if (!done) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic start_and_time(input int n, output int c);
        bit got;
        start = 1'b1;
        len   = LEN_W'(n);
        c     = 0;
        got   = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(posedge clk);
            c++;
            #1;
            start = 1'b0;
            @(negedge clk);
            if (res_valid) got = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int n, input int gapmode);
        sb.push_back(model(n));
        issue_start(n);
        feed(n, gapmode, 1'b0);
        wait_idle();
    endtask

    initial begin
        int  c;
        bit  got;

        // Power-on reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("por");
        reset = 1'b0;
        tick();

        // Single pair with held result, latency, and start ignored in DONE.
        rdy_mode = 2;
        tick();
        sb.push_back('{z: 38'h0FFFF60001, ovf: 1'b0});
        op_valid = 1'b1;
        op_a     = 20'h7FFFF;
        op_b     = 18'h1FFFF;
        start_and_time(1, c);
        op_valid = 1'b0;
        chk("latency_len1", 64'(c), 64'(2 + PIPE));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_res_valid", 64'(res_valid), 64'd1);
            chk("hold_res_z", 64'(res_z), 64'h0FFFF60001);
        end
        @(posedge clk);
        #1;
        issue_start(3);
        @(negedge clk);
        chk("start_in_done_valid", 64'(res_valid), 64'd1);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        wait_idle();
        tick();
        tick();
        chk("start_in_done_ignored", 64'(busy), 64'd0);
        chk("res_z_held_idle", 64'(res_z), 64'h0FFFF60001);

        // Stream with a two-cycle gap.
        for (int i = 0; i < 4; i++) begin
            ja[i] = 20'(i + 1);
            jb[i] = 18'd10;
        end
        sb.push_back('{z: 38'd100, ovf: 1'b0});
        issue_start(4);
        feed(4, 1, 1'b1);
        wait_idle();

        // Overflow.
        for (int i = 0; i < 3; i++) begin
            ja[i] = 20'hFFFFF;
            jb[i] = 18'h3FFFF;
        end
        sb.push_back('{z: 38'h3FFFC40003, ovf: 1'b1});
        issue_start(3);
        feed(3, 0, 1'b0);
        wait_idle();

        // len==0 with junk operands offered outside RUN.
        sb.push_back('{z: 38'd0, ovf: 1'b0});
        op_valid = 1'b1;
        op_a     = 20'h12345;
        op_b     = 18'h2ABCD;
        rdy_mode = 2;
        start_and_time(0, c);
        chk("latency_len0", 64'(c), 64'd1);
        rdy_mode = 0;
        wait_idle();
        op_valid = 1'b0;

        // Reset while a result is held in DONE, with random inputs.
        rdy_mode = 2;
        ja[0] = 20'd7;
        jb[0] = 18'd9;
        sb.push_back('{z: 38'd63, ovf: 1'b0});
        issue_start(1);
        feed(1, 0, 1'b0);
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            if (res_valid) got = 1'b1;
            else tick();
        end
        chk("reach_done", 64'(got), 64'd1);
        @(posedge clk);
        #3;
        reset    = 1'b1;
        op_valid = 1'($urandom);
        op_a     = 20'($urandom);
        op_b     = 18'($urandom);
        start    = 1'($urandom);
        len      = LEN_W'($urandom);
        sb.delete();
        #1;
        chk_outputs_zero("rst_now");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_outputs_zero("rst_hold");
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        op_valid = 1'b0;
        reset    = 1'b0;
        rdy_mode = 0;
        tick();

        // Reset mid-RUN after two of five pairs.
        for (int i = 0; i < 5; i++) begin
            ja[i] = 20'(i + 1);
            jb[i] = 18'd2;
        end
        issue_start(5);
        feed(2, 0, 1'b0);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("midrun_rst_busy", 64'(busy), 64'd0);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("midrun_no_job", 64'(busy), 64'd0);
        ja[0] = 20'd3;
        jb[0] = 18'd5;
        sb.push_back('{z: 38'd15, ovf: 1'b0});
        issue_start(1);
        feed(1, 0, 1'b0);
        wait_idle();

        // Random jobs with operand gaps and result stalls.
        rdy_mode = 1;
        for (int j = 0; j < 600; j++) begin
            int n;
            n = $urandom_range(1, 16);
            for (int i = 0; i < 16; i++) begin
                ja[i] = 20'($urandom);
                jb[i] = 18'($urandom);
            end
            run_job(n, 2);
        end

        rdy_mode = 0;
        repeat (5) tick();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
